// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, debounces the
// synchronized rows on scan ticks and reports each accepted key press exactly once.
module keypad_scanner #(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  state_t          r_state;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_col;
  logic [1:0]      r_row;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            r_key_held;

  logic            w_single;
  logic [1:0]      w_row_idx;
  logic            w_row_low;
  logic [CW-1:0]   w_cnt_nxt;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two or more low rows (ghosting / multi-press) is treated the same as no key.
  always_comb begin
    w_single  = 1'b0;
    w_row_idx = 2'd0;
    case (r_sync2)
      4'b1110: begin w_single = 1'b1; w_row_idx = 2'd0; end
      4'b1101: begin w_single = 1'b1; w_row_idx = 2'd1; end
      4'b1011: begin w_single = 1'b1; w_row_idx = 2'd2; end
      4'b0111: begin w_single = 1'b1; w_row_idx = 2'd3; end
      default: begin w_single = 1'b0; w_row_idx = 2'd0; end
    endcase
  end

  assign w_row_low = ~r_sync2[r_row];
  assign w_cnt_nxt = r_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SCAN;
      r_sync1     <= 4'b1111;
      r_sync2     <= 4'b1111;
      r_cnt       <= '0;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= rows;
      r_sync2     <= r_sync1;
      r_key_valid <= 1'b0;
      if (tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_single) begin
              r_row <= w_row_idx;
              r_cnt <= CW'(1);
              if (DEBOUNCE_TICKS == 1) begin
                r_state     <= S_HELD;
                r_key_code  <= key_map(w_row_idx, r_col);
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_state <= S_DEBOUNCE;
              end
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
          S_DEBOUNCE: begin
            if (w_single && (w_row_idx == r_row)) begin
              if (w_cnt_nxt >= C_LIMIT) begin
                r_state     <= S_HELD;
                r_cnt       <= '0;
                r_key_code  <= key_map(r_row, r_col);
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end else begin
              r_cnt   <= '0;
              r_col   <= r_col + 2'd1;
              r_state <= S_SCAN;
            end
          end
          // Column stays frozen here, so other keys in other columns cannot be seen.
          S_HELD: begin
            if (!w_row_low) begin
              if (DEBOUNCE_TICKS == 1) begin
                r_cnt      <= '0;
                r_key_held <= 1'b0;
                r_col      <= r_col + 2'd1;
                r_state    <= S_SCAN;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (!w_row_low) begin
              if (w_cnt_nxt >= C_LIMIT) begin
                r_cnt      <= '0;
                r_key_held <= 1'b0;
                r_col      <= r_col + 2'd1;
                r_state    <= S_SCAN;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= S_HELD;
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  assign cols      = ~(4'b0001 << r_col);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows, a queue of
// expected key codes is filled as presses are issued and drained by a valid monitor.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       pressed [4][4];
  logic [3:0] exp_q [$];
  int         n_tests;
  int         n_fails;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  keypad_scanner #(.DEBOUNCE_TICKS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // A pressed key shorts its row to its column; a row is low when any pressed key
  // in it sits on the column currently driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && key_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fails++;
        $display("FAIL unexpected_valid: got code %0h, required no event", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("event_code", key_code, e);
        check("event_held", key_held, 1);
      end
    end
  end

  task automatic wait_tick();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (tick) break;
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic wait_cols(input logic [3:0] pat);
    for (int i = 0; i < 8; i++) begin
      if (cols == pat) break;
      wait_tick();
    end
  endtask

  task automatic wait_held(input logic v, input int max_ticks);
    for (int i = 0; i < max_ticks; i++) begin
      if (key_held == v) break;
      wait_tick();
    end
    check("held_wait", key_held, v);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] prev;
    logic [3:0] seen;
    n_tests = 0;
    n_fails = 0;
    release_all();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cols", cols, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      prev = cols;
      wait_tick();
      check("rotate", cols, {prev[2:0], prev[3]});
    end

    // Asynchronous reset while the scan sits on column 2.
    wait_cols(4'b1011);
    check("pre_reset_col2", cols, 4'b1011);
    reset = 1'b0;
    #1;
    check("mid_rst_cols", cols, 4'b1110);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_code", key_code, 4'h0);
    @(negedge clk);
    reset = 1'b1;

    // Hold '5' (row1, col1): one event, column frozen.
    wait_cols(4'b1101);
    pressed[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_held(1'b1, 20);
    check("hold5_code", key_code, 4'h5);
    for (int i = 0; i < 6; i++) begin
      wait_tick();
      check("hold5_frozen", cols, 4'b1101);
    end

    // Press '9' while '5' held, then release '5'.
    pressed[2][2] = 1'b1;
    exp_q.push_back(4'h9);
    ticks(3);
    pressed[1][1] = 1'b0;
    wait_held(1'b0, 15);
    check("code_holds", key_code, 4'h5);
    for (int i = 0; i < 20; i++) begin
      if (key_code == 4'h9) break;
      wait_tick();
    end
    check("code9", key_code, 4'h9);
    check("held9", key_held, 1);
    pressed[2][2] = 1'b0;
    wait_held(1'b0, 15);
    ticks(4);

    // Short press on row0/col0: no event, scan resumes.
    wait_cols(4'b1110);
    pressed[0][0] = 1'b1;
    ticks(3);
    check("short_frozen", cols, 4'b1110);
    pressed[0][0] = 1'b0;
    wait_tick(); check("resume1", cols, 4'b1101);
    wait_tick(); check("resume2", cols, 4'b1011);
    wait_tick(); check("resume3", cols, 4'b0111);
    wait_tick(); check("resume4", cols, 4'b1110);

    // Two rows low on col3: ghost, no key, column keeps rotating.
    pressed[1][3] = 1'b1;
    pressed[2][3] = 1'b1;
    seen = 4'h0;
    for (int i = 0; i < 12; i++) begin
      wait_tick();
      for (int c = 0; c < 4; c++) if (!cols[c]) seen[c] = 1'b1;
    end
    check("ghost_rotate", seen, 4'hF);
    check("ghost_held", key_held, 0);
    release_all();
    ticks(2);

    // Release bounce returns to HELD; then reset while held.
    pressed[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_held(1'b1, 20);
    pressed[1][1] = 1'b0;
    ticks(3);
    pressed[1][1] = 1'b1;
    ticks(10);
    check("bounce_held", key_held, 1);
    check("bounce_cols", cols, 4'b1101);
    reset = 1'b0;
    #1;
    check("held_rst_held", key_held, 0);
    check("held_rst_cols", cols, 4'b1110);
    check("held_rst_code", key_code, 4'h0);
    exp_q.push_back(4'h5);
    @(negedge clk);
    reset = 1'b1;
    wait_held(1'b1, 20);
    check("redetect_code", key_code, 4'h5);
    pressed[1][1] = 1'b0;
    wait_held(1'b0, 15);
    ticks(4);

    // Randomized presses against the press-level model.
    for (int ev = 0; ev < 14; ev++) begin
      int kind;
      int r;
      int c;
      kind = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if (kind == 0) begin
        pressed[r][c] = 1'b1;
        ticks($urandom_range(1, 5));
        pressed[r][c] = 1'b0;
      end else if (kind == 3) begin
        pressed[r][c] = 1'b1;
        pressed[(r + 1) % 4][c] = 1'b1;
        ticks(10);
        release_all();
      end else begin
        pressed[r][c] = 1'b1;
        exp_q.push_back(KEYMAP[r][c]);
        if ($urandom_range(0, 1) == 1) begin
          ticks(14);
          pressed[r][c] = 1'b0;
          ticks(2);
          pressed[r][c] = 1'b1;
          ticks(4);
        end else begin
          ticks($urandom_range(16, 24));
        end
        check("rand_held", key_held, 1);
        pressed[r][c] = 1'b0;
      end
      ticks(12);
      check("rand_released", key_held, 0);
    end

    ticks(5);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
